gtlp_bus_arbiter: RTL
=====================

# gtlp_bus_arbiter

Sequencing and sharing controller for a shared GTLP tri-state pad bus built from per-bit tri-state output buffers. Up to N_REQ on-chip requesters compete for the bus. The block grants one owner at a time with round-robin fairness and a bounded burst length. It drives the buffers' data (I) and tri-state control (T, 1 = high-Z), and inserts mandatory high-Z turnaround cycles between owners so that two drivers never overlap.

## Interface
Parameters:
- N_REQ, 4, number of requesters (≥2)
- WIDTH, 8, pad bus width
- MAX_BURST, 16, maximum words per grant (≥1)
- TURN_CYC, 1, turnaround cycles in TURN state (≥1)

Ports:
- CLK  in  1  single clock, rising edge
- CLR_N  in  1  reset, asynchronous, active-low
- REQ  in  N_REQ  per-requester request; held high for the whole burst
- LAST  in  N_REQ  per-requester final-word flag, qualified by GNT & REQ
- DIN  in  N_REQ*WIDTH  flattened data, requester k at bits [k*WIDTH +: WIDTH]
- FORCE_Z  in  1  synchronous forced release: bus to high-Z, no new grants
- GNT  out  N_REQ  one-hot grant, word accepted when GNT[k] & REQ[k]
- PAD_I  out  WIDTH  registered data to buffer I inputs
- PAD_T  out  1  registered tri-state control broadcast to all buffer T inputs, 1 = high-Z
- BUSY  out  1  high in DRIVE or TURN

## Operation
- States: IDLE, DRIVE, TURN. Registers: state, owner, ptr (last owner), burst cnt, turn cnt, PAD_I, PAD_T.
- Reset values: state IDLE, ptr N_REQ-1 (requester 0 wins first), cnt 0, GNT 0, PAD_I 0, PAD_T 1, BUSY 0.
- IDLE: if FORCE_Z=0 and |REQ, pick the first set REQ searching from ptr+1 with wrap modulo N_REQ. Set owner, set ptr to the winner, clear cnt, go to DRIVE. Otherwise stay in IDLE.
- DRIVE: GNT[owner]=1, decoded from registered state and owner.
  - Capture cycle: REQ[owner]=1 and FORCE_Z=0. PAD_I ← DIN[owner], PAD_T ← 0, cnt increments.
  - Exit to TURN on any of: a capture with LAST[owner]=1; a capture with cnt==MAX_BURST-1; REQ[owner]=0; FORCE_Z=1. The last two exit without a capture.
- TURN: GNT=0, PAD_T ← 1. Stay TURN_CYC cycles, then go to IDLE.
- PAD_T ← 1 on every non-capture cycle. PAD_T is never 0 outside the cycle immediately following a capture.
- Counter widths: cnt is $clog2(MAX_BURST)+1 bits; turn cnt is $clog2(TURN_CYC)+1 bits. cnt never exceeds MAX_BURST.
- Simultaneous events:
  - LAST and cnt limit together: single exit to TURN.
  - FORCE_Z together with LAST: FORCE_Z wins and no capture occurs.
  - A requester re-requesting in TURN waits for IDLE arbitration and loses to any other pending requester (ptr moved past it).
- LAST on a non-owner, or when GNT is low, is ignored.
- Reset mid-operation: all outputs return asynchronously to their reset values. PAD_T=1 takes effect immediately, without waiting for a clock edge.

## Timing
- Arbitration: REQ sampled in IDLE at edge e. GNT is high from e (DRIVE in the following cycle).
- Data latency: a word captured at edge e appears on PAD_I with PAD_T=0 for exactly the cycle after e.
- Throughput: one word per cycle per owner while REQ is held.
- Owner-change gap: PAD_T=1 for exactly TURN_CYC+1 cycles between the last driven cycle of owner A and the first driven cycle of owner B (TURN_CYC in TURN plus 1 in IDLE).
- FORCE_Z asserted at edge e gives PAD_T=1 from the cycle after e. It is held for as long as FORCE_Z stays high, plus the TURN/IDLE sequence.

## Structure
- Shared package gtlp_arb_pkg:
  - state enum: IDLE, DRIVE, TURN
  - helper constants for counter widths
- One sub-module, gtlp_rr_pick: combinational round-robin picker. Inputs are req vector and ptr; outputs are one-hot winner, winner index and valid.
- Top-level holds the FSM, counters and output registers. PAD_T and PAD_I are flops with no combinational path to the pads.

## Test plan
- Reset: assert CLR_N=0 mid-sim with REQ=4'b1111 -> PAD_T=1, GNT=0, PAD_I=0, BUSY=0 asynchronously. After release, requester 0 is granted first.
- Single burst: REQ[0] with DIN words 0x11,0x22,0x33, LAST on 0x33 -> PAD_I=0x11,0x22,0x33 on three consecutive cycles with PAD_T=0. Then PAD_T=1 and GNT=0.
- Contention: REQ=4'b0011 after reset, each sending 2 words with LAST, TURN_CYC=1 -> requester 0 drives 2 cycles, then exactly 2 high-Z cycles, then requester 1 drives 2 cycles. PAD_T is never 0 across the gap.
- Burst cap: MAX_BURST=4, REQ[2] and REQ[3] held with no LAST -> 2 drives exactly 4 words, then 3 drives 4 words, then 2 again (round-robin).
- FORCE_Z: assert FORCE_Z on the 2nd word of a 5-word burst -> only 1 word driven. PAD_T=1 while FORCE_Z is high, with no grants. After deassertion the same requester re-arbitrates.
- REQ drop: requester 1 deasserts REQ after 2 words without LAST -> no capture that cycle, TURN entered, PAD_T=1 the next cycle.

Source files
------------

// File: rtl/gtlp_arb_pkg.sv
// ---------------------------------------------------------------------------
// gtlp_arb_pkg : shared state encoding and width helpers for the GTLP arbiter
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package gtlp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } arb_state_e;

    function automatic int cnt_width(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gtlp_rr_pick.sv
// ---------------------------------------------------------------------------
// gtlp_rr_pick : combinational round-robin picker, search starts at ptr+1
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gtlp_rr_pick
    import gtlp_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_oh_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    logic [IW:0] cand;
    logic        found;

    // One extra bit so ptr+i can exceed N before the modulo fold
    always_comb begin
        grant_oh_o = '0;
        idx_o      = '0;
        found      = 1'b0;
        cand       = '0;
        for (int i = 1; i <= N; i++) begin
            cand = {1'b0, ptr_i} + (IW+1)'(i);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!found && req_i[cand[IW-1:0]]) begin
                found                        = 1'b1;
                idx_o                        = cand[IW-1:0];
                grant_oh_o[cand[IW-1:0]]     = 1'b1;
            end
        end
        valid_o = found;
    end

endmodule

`default_nettype wire

// File: rtl/gtlp_bus_arbiter.sv
// ---------------------------------------------------------------------------
// gtlp_bus_arbiter : round-robin owner sequencing for a shared tri-state pad
//                    bus with bounded bursts and high-Z turnaround
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gtlp_bus_arbiter
    import gtlp_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 16,
    parameter int TURN_CYC  = 1
) (
    input  logic                   CLK,
    input  logic                   CLR_N,
    input  logic [N_REQ-1:0]       REQ,
    input  logic [N_REQ-1:0]       LAST,
    input  logic [N_REQ*WIDTH-1:0] DIN,
    input  logic                   FORCE_Z,
    output logic [N_REQ-1:0]       GNT,
    output logic [WIDTH-1:0]       PAD_I,
    output logic                   PAD_T,
    output logic                   BUSY
);

    localparam int c_iw = idx_width(N_REQ);
    localparam int c_cw = cnt_width(MAX_BURST);
    localparam int c_tw = cnt_width(TURN_CYC);

    arb_state_e        state_q, state_d;
    logic [c_iw-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0]  owner_oh_q, owner_oh_d;
    logic [c_cw-1:0]   cnt_q, cnt_d;
    logic [c_tw-1:0]   tcnt_q, tcnt_d;
    logic [WIDTH-1:0]  pad_i_q, pad_i_d;
    logic              pad_t_q, pad_t_d;

    logic [N_REQ-1:0]  w_pick_oh;
    logic [c_iw-1:0]   w_pick_idx;
    logic              w_pick_valid;
    logic [WIDTH-1:0]  w_din_arr [N_REQ];
    logic              w_own_req;
    logic              w_own_last;

    genvar k;
    generate
        for (k = 0; k < N_REQ; k++) begin : g_din
            assign w_din_arr[k] = DIN[k*WIDTH +: WIDTH];
        end
    endgenerate

    gtlp_rr_pick #(
        .N  (N_REQ),
        .IW (c_iw)
    ) u_pick (
        .req_i      (REQ),
        .ptr_i      (ptr_q),
        .grant_oh_o (w_pick_oh),
        .idx_o      (w_pick_idx),
        .valid_o    (w_pick_valid)
    );

    // ptr always equals the current owner's index once a grant is made
    assign w_own_req  = |(REQ & owner_oh_q);
    assign w_own_last = |(LAST & owner_oh_q);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_oh_d = owner_oh_q;
        cnt_d      = cnt_q;
        tcnt_d     = tcnt_q;
        pad_i_d    = pad_i_q;
        pad_t_d    = 1'b1;
        case (state_q)
            IDLE: begin
                if (!FORCE_Z && w_pick_valid) begin
                    state_d    = DRIVE;
                    ptr_d      = w_pick_idx;
                    owner_oh_d = w_pick_oh;
                    cnt_d      = '0;
                end
            end
            DRIVE: begin
                if (FORCE_Z || !w_own_req) begin
                    state_d = TURN;
                    tcnt_d  = '0;
                end else begin
                    pad_i_d = w_din_arr[ptr_q];
                    pad_t_d = 1'b0;
                    cnt_d   = cnt_q + 1'b1;
                    if (w_own_last || cnt_q == c_cw'(MAX_BURST - 1)) begin
                        state_d = TURN;
                        tcnt_d  = '0;
                    end
                end
            end
            TURN: begin
                if (tcnt_q == c_tw'(TURN_CYC - 1)) begin
                    state_d = IDLE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q    <= IDLE;
            ptr_q      <= c_iw'(N_REQ - 1);
            owner_oh_q <= '0;
            cnt_q      <= '0;
            tcnt_q     <= '0;
            pad_i_q    <= '0;
            pad_t_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_oh_q <= owner_oh_d;
            cnt_q      <= cnt_d;
            tcnt_q     <= tcnt_d;
            pad_i_q    <= pad_i_d;
            pad_t_q    <= pad_t_d;
        end
    end

    assign GNT   = (state_q == DRIVE) ? owner_oh_q : '0;
    assign PAD_I = pad_i_q;
    assign PAD_T = pad_t_q;
    assign BUSY  = (state_q != IDLE);

endmodule

`default_nettype wire
